// File: rtl/seg7_scan.sv
// Time-multiplexed hex driver for a common-anode seven-segment display.
// Steps one digit per rising edge of an asynchronous scan strobe and snapshots its inputs per frame.
module seg7_scan #(
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_in,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lz_en,
  input  logic                    blank,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_start
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic                    s1_r, s2_r, s3_r;
  logic [IW-1:0]           idx_r;
  logic [4*NUM_DIGITS-1:0] data_r;
  logic [NUM_DIGITS-1:0]   dpm_r;
  logic                    lz_r;

  logic                    step_s;
  logic                    wrap_s;
  logic [IW-1:0]           next_idx_s;
  logic [4*NUM_DIGITS-1:0] eff_data_s;
  logic [NUM_DIGITS-1:0]   eff_dpm_s;
  logic                    eff_lz_s;
  logic [NUM_DIGITS-1:0]   lz_dark_s;
  logic                    run_zero_s;
  logic [3:0]              nib_s;
  logic [NUM_DIGITS-1:0]   an_next_s;
  logic [6:0]              seg_next_s;
  logic                    dp_next_s;

  assign step_s     = s2_r & ~s3_r;
  assign wrap_s     = (idx_r == LAST_IDX);
  assign next_idx_s = wrap_s ? '0 : idx_r + IW'(1);
  // On a wrap the digit-0 outputs decode the value being captured on the same edge.
  assign eff_data_s = wrap_s ? data_in : data_r;
  assign eff_dpm_s  = wrap_s ? dp_mask : dpm_r;
  assign eff_lz_s   = wrap_s ? lz_en   : lz_r;
  assign nib_s      = eff_data_s[{next_idx_s, 2'b00} +: 4];

  // Leading-zero mask: a digit goes dark when it and every digit above it are zero.
  always_comb begin
    lz_dark_s  = '0;
    run_zero_s = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run_zero_s   = run_zero_s & (eff_data_s[4*i +: 4] == 4'h0);
      lz_dark_s[i] = eff_lz_s & run_zero_s & (i != 0) & ~eff_dpm_s[i];
    end
  end

  // Output pattern for the digit about to be driven.
  always_comb begin
    an_next_s  = '1;
    seg_next_s = 7'h7F;
    dp_next_s  = 1'b1;
    if (!lz_dark_s[next_idx_s]) begin
      an_next_s[next_idx_s] = 1'b0;
      seg_next_s            = hex_to_seg(nib_s);
      dp_next_s             = ~eff_dpm_s[next_idx_s];
    end else begin
      an_next_s  = '1;
      seg_next_s = 7'h7F;
      dp_next_s  = 1'b1;
    end
  end

  // Strobe synchronizer, digit counter, frame snapshot and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r        <= 1'b0;
      s2_r        <= 1'b0;
      s3_r        <= 1'b0;
      idx_r       <= LAST_IDX;
      data_r      <= '0;
      dpm_r       <= '0;
      lz_r        <= 1'b0;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      s1_r        <= tick_in;
      s2_r        <= s1_r;
      s3_r        <= s2_r;
      frame_start <= step_s & wrap_s;
      if (step_s) begin
        idx_r <= next_idx_s;
        if (wrap_s) begin
          data_r <= data_in;
          dpm_r  <= dp_mask;
          lz_r   <= lz_en;
        end
      end
      // Blanking takes effect at once; un-blanking waits for the next step.
      if (blank) begin
        an  <= '1;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else if (step_s) begin
        an  <= an_next_s;
        seg <= seg_next_s;
        dp  <= dp_next_s;
      end else begin
        an  <= an;
        seg <= seg;
        dp  <= dp;
      end
    end
  end

endmodule
